// File: rtl/buzzer_dma_arb.sv
// Arbitrates BGM and Sound DMA single-beat reads onto one AHB-lite ROM port.
// Latency: request seen in IDLE -> x_HREADY at +3 cycles, plus one per ROM wait state.
// Backpressure: requester holds HTRANS/HADDR until its HREADY; ROM stalls via M_HREADY.
module buzzer_dma_arb #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int SND_MAX_BURST = 4,
  parameter int SND_PRI       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] B_HADDR,
  input  logic [1:0]        B_HTRANS,
  output logic [DATA_W-1:0] B_HRDATA,
  output logic              B_HREADY,
  input  logic [ADDR_W-1:0] S_HADDR,
  input  logic [1:0]        S_HTRANS,
  output logic [DATA_W-1:0] S_HRDATA,
  output logic              S_HREADY,
  output logic [ADDR_W-1:0] M_HADDR,
  output logic [1:0]        M_HTRANS,
  output logic              M_HWRITE,
  input  logic [DATA_W-1:0] M_HRDATA,
  input  logic              M_HREADY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic [3:0] MAX_CNT = 4'(SND_MAX_BURST);

  logic [1:0] state;
  logic       grant_snd;
  logic [3:0] cnt;
  logic       rr_last_bgm;
  logic       req_b;
  logic       req_s;
  logic       pick_snd;
  logic       unused_htrans;

  assign req_b         = B_HTRANS[1];
  assign req_s         = S_HTRANS[1];
  assign unused_htrans = ^{B_HTRANS[0], S_HTRANS[0]};

  // Contention only: Sound wins until its burst budget is spent, or strict alternation.
  always_comb begin
    pick_snd = req_s;
    if (req_b && req_s) begin
      if (SND_PRI != 0) pick_snd = (cnt != MAX_CNT);
      else              pick_snd = rr_last_bgm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_snd   <= 1'b0;
      cnt         <= 4'd0;
      rr_last_bgm <= 1'b0;
      M_HADDR     <= '0;
      M_HTRANS    <= 2'b00;
      B_HRDATA    <= '0;
      S_HRDATA    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_b || req_s) begin
            grant_snd   <= pick_snd;
            rr_last_bgm <= ~pick_snd;
            M_HADDR     <= pick_snd ? S_HADDR : B_HADDR;
            M_HTRANS    <= 2'b10;
            state       <= ST_ADDR;
          end
          // Counts only Sound grants that made BGM wait.
          if (!req_b || !pick_snd)  cnt <= 4'd0;
          else if (cnt != MAX_CNT)  cnt <= cnt + 4'd1;
        end
        ST_ADDR: begin
          if (M_HREADY) begin
            M_HTRANS <= 2'b00;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (M_HREADY) begin
            if (grant_snd) S_HRDATA <= M_HRDATA;
            else           B_HRDATA <= M_HRDATA;
            state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign B_HREADY = ~req_b | ((state == ST_RESP) & ~grant_snd);
  assign S_HREADY = ~req_s | ((state == ST_RESP) &  grant_snd);
  assign M_HWRITE = 1'b0;

endmodule

// File: tb/tb_buzzer_dma_arb.sv
// Directed bench: priority instance plus an alternation instance, scoreboard of expected completions.
// ROM model returns addr ^ 0xA4A5 with a bench-controlled wait state.
module tb_buzzer_dma_arb;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // Priority instance
  logic        b_req, s_req, rom_rdy;
  logic [31:0] b_addr, s_addr;
  logic [31:0] B_HRDATA, S_HRDATA, M_HADDR, M_HRDATA;
  logic        B_HREADY, S_HREADY, M_HWRITE;
  logic [1:0]  M_HTRANS;

  // Alternation instance
  logic        r_b_req, r_s_req;
  logic [31:0] rB_HRDATA, rS_HRDATA, rM_HADDR, rM_HRDATA;
  logic        rB_HREADY, rS_HREADY, rM_HWRITE;
  logic [1:0]  rM_HTRANS;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return a ^ 32'h0000_A4A5;
  endfunction

  assign M_HRDATA  = rom_f(M_HADDR);
  assign rM_HRDATA = rom_f(rM_HADDR);

  buzzer_dma_arb #(.ADDR_W(32), .DATA_W(32), .SND_MAX_BURST(4), .SND_PRI(1)) u_dut (
    .clk(clk), .rst(rst),
    .B_HADDR(b_addr), .B_HTRANS({b_req, 1'b0}), .B_HRDATA(B_HRDATA), .B_HREADY(B_HREADY),
    .S_HADDR(s_addr), .S_HTRANS({s_req, 1'b0}), .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
    .M_HRDATA(M_HRDATA), .M_HREADY(rom_rdy)
  );

  buzzer_dma_arb #(.ADDR_W(32), .DATA_W(32), .SND_MAX_BURST(4), .SND_PRI(0)) u_rr (
    .clk(clk), .rst(rst),
    .B_HADDR(32'h0000_0300), .B_HTRANS({r_b_req, 1'b0}), .B_HRDATA(rB_HRDATA), .B_HREADY(rB_HREADY),
    .S_HADDR(32'h0000_0400), .S_HTRANS({r_s_req, 1'b0}), .S_HRDATA(rS_HRDATA), .S_HREADY(rS_HREADY),
    .M_HADDR(rM_HADDR), .M_HTRANS(rM_HTRANS), .M_HWRITE(rM_HWRITE),
    .M_HRDATA(rM_HRDATA), .M_HREADY(1'b1)
  );

  typedef struct {
    bit          snd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   rr_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   s_left   = 0;
  int   b_left   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit snd, input logic [31:0] addr);
    exp_t e;
    e.snd  = snd;
    e.data = rom_f(addr);
    exp_q.push_back(e);
  endtask

  // Requester model: on completion compare against the scoreboard, then re-request or drop.
  task automatic service();
    bit          side;
    logic [31:0] data;
    exp_t        e;
    if ((s_req && S_HREADY) || (b_req && B_HREADY)) begin
      side = s_req && S_HREADY;
      data = side ? S_HRDATA : B_HRDATA;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_completion observed side=%0d expected none", side);
      end else begin
        e = exp_q.pop_front();
        check("grant_side", 32'(side), 32'(e.snd));
        check("read_data", data, e.data);
      end
      if (side) begin
        if (s_left > 0) begin s_left--; s_addr += 4; end else s_req = 1'b0;
      end else begin
        if (b_left > 0) begin b_left--; b_addr += 4; end else b_req = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      service();
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $error("FAIL drain_timeout observed pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    string order;
    int    si, bi;
    bit    side;

    rst = 1'b1; b_req = 1'b0; s_req = 1'b0; rom_rdy = 1'b1;
    b_addr = '0; s_addr = '0; r_b_req = 1'b0; r_s_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_m_htrans", 32'(M_HTRANS), 32'd0);
    check("rst_m_haddr", M_HADDR, 32'd0);
    check("rst_b_hrdata", B_HRDATA, 32'd0);
    check("rst_s_hrdata", S_HRDATA, 32'd0);
    check("rst_b_hready", 32'(B_HREADY), 32'd1);
    check("rst_s_hready", 32'(S_HREADY), 32'd1);
    check("m_hwrite", 32'(M_HWRITE), 32'd0);

    // 1: single Sound read, zero wait states
    s_addr = 32'h100; s_req = 1'b1; s_left = 0;
    push(1'b1, 32'h100);
    tick();
    check("t1_c1_htrans", 32'(M_HTRANS), 32'd2);
    check("t1_c1_haddr", M_HADDR, 32'h100);
    check("t1_c1_hready", 32'(S_HREADY), 32'd0);
    tick();
    check("t1_c2_htrans", 32'(M_HTRANS), 32'd0);
    check("t1_c2_hready", 32'(S_HREADY), 32'd0);
    tick();
    check("t1_c3_hready", 32'(S_HREADY), 32'd1);
    check("t1_c3_hrdata", S_HRDATA, 32'h0000_A5A5);
    service();
    tick();

    // 2: both continuous, Sound burst limit of 4
    s_addr = 32'h1000; b_addr = 32'h2000; s_left = 7; b_left = 1;
    s_req = 1'b1; b_req = 1'b1;
    order = "SSSSBSSSSB";
    si = 0; bi = 0;
    for (int k = 0; k < order.len(); k++) begin
      if (order[k] == "S") begin push(1'b1, 32'h1000 + 32'(4 * si)); si++; end
      else begin push(1'b0, 32'h2000 + 32'(4 * bi)); bi++; end
    end
    drain(200);

    // 3: ROM wait states, 2 in address phase and 3 in data phase
    tick();
    b_addr = 32'h2400; b_req = 1'b1; b_left = 0; rom_rdy = 1'b1;
    push(1'b0, 32'h2400);
    for (int c = 1; c <= 7; c++) begin
      tick();
      rom_rdy = (c == 3) || (c == 7);
      check("t3_b_hready_wait", 32'(B_HREADY), 32'd0);
      if (c <= 3) begin
        check("t3_htrans_hold", 32'(M_HTRANS), 32'd2);
        check("t3_haddr_hold", M_HADDR, 32'h2400);
      end
    end
    tick();
    check("t3_c8_hready", 32'(B_HREADY), 32'd1);
    service();
    rom_rdy = 1'b1;

    // 4: BGM withdraws during data phase, pending Sound goes next
    tick();
    b_addr = 32'h2800; b_req = 1'b1; b_left = 0;
    tick();
    s_addr = 32'h1800; s_req = 1'b1; s_left = 0;
    push(1'b1, 32'h1800);
    tick();
    b_req = 1'b0;
    #1;
    check("t4_b_hready_drop", 32'(B_HREADY), 32'd1);
    tick();
    check("t4_b_hrdata_captured", B_HRDATA, rom_f(32'h2800));
    check("t4_s_hready_resp", 32'(S_HREADY), 32'd0);
    for (int c = 4; c <= 7; c++) begin
      tick();
      check("t4_s_hready", 32'(S_HREADY), 32'(c == 7));
      service();
    end
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset in data phase with a partly used burst budget
    tick();
    s_addr = 32'h3000; b_addr = 32'h3800; s_left = 100; b_left = 100;
    s_req = 1'b1; b_req = 1'b1;
    push(1'b1, 32'h3000);
    push(1'b1, 32'h3004);
    drain(50);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_m_htrans", 32'(M_HTRANS), 32'd0);
    check("t5_m_haddr", M_HADDR, 32'd0);
    check("t5_s_hrdata", S_HRDATA, 32'd0);
    check("t5_b_hrdata", B_HRDATA, 32'd0);
    check("t5_s_hready", 32'(S_HREADY), 32'd0);
    s_left = 3; b_left = 0;
    for (int k = 0; k < 4; k++) push(1'b1, s_addr + 32'(4 * k));
    push(1'b0, b_addr);
    drain(100);
    tick();

    // 6: alternation instance, both requesting from reset
    r_b_req = 1'b1; r_s_req = 1'b1;
    rr_q.push_back(1'b0); rr_q.push_back(1'b1); rr_q.push_back(1'b0); rr_q.push_back(1'b1);
    for (int n = 0; n < 60 && rr_q.size() > 0; n++) begin
      tick();
      if (rB_HREADY || rS_HREADY) begin
        side = rS_HREADY;
        check("t6_rr_side", 32'(side), 32'(rr_q.pop_front()));
        check("t6_rr_data", side ? rS_HRDATA : rB_HRDATA,
              rom_f(side ? 32'h400 : 32'h300));
      end
    end
    if (rr_q.size() > 0) begin
      checks++;
      failures++;
      $error("FAIL t6_timeout observed pending=%0d expected 0", rr_q.size());
    end
    r_b_req = 1'b0; r_s_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
